// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
//   EDGE_*  : per-channel edge-mode encodings (which edges set the sticky event)
//   clog2   : ceiling log2, used to size the debounce counter
package input_conditioner_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioner channel: synchroniser, optional debounce, edge detect and
// sticky event flag.
// Build option: INPUT_CONDITIONER_DEBOUNCE_EN instantiates the debounce counter;
// when undefined, s is a single register after the sync chain.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   u           : raw asynchronous input
//   evt_clr     : synchronous clear of evt
//   s           : conditioned level
//   rise, fall  : one-cycle pulses aligned with the new s value
//   evt         : sticky event flag (edges selected by EDGE_MODE)
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_VALUE     = 1'b0,
  parameter logic [1:0]  EDGE_MODE       = EDGE_BOTH
) (
  input  logic clk,
  input  logic nreset,
  input  logic u,
  input  logic evt_clr,
  output logic s,
  output logic rise,
  output logic fall,
  output logic evt
);

  // Elaboration-time parameter sanity.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cond_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("cond_channel: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam logic SET_ON_RISE = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
  localparam logic SET_ON_FALL = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   y;
  logic                   s_q, s_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   evt_q, evt_d;

  // Synchroniser shift chain; last stage is the clk-domain level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], u};
  end

  assign y = sync_q[SYNC_STAGES-1];

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int unsigned      CNT_W   = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of y disagreeing with s; any agreement restarts.
  always_comb begin
    cnt_d = '0;
    s_d   = s_q;
    if (y != s_q) begin
      if (cnt_q == CNT_MAX) begin
        s_d = y;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  // No debounce: every synchronised transition is taken.
  always_comb begin
    s_d = y;
  end
`endif

  // Edges are detected on the next-state value so pulses line up with new s.
  always_comb begin
    rise_d = s_d & ~s_q;
    fall_d = ~s_d & s_q;
    // Set has priority over a simultaneous clear.
    evt_d  = (evt_q & ~evt_clr) | (rise_q & SET_ON_RISE) | (fall_q & SET_ON_FALL);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      s_q    <= RESET_VALUE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_q    <= s_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
    end
  end

  assign s    = s_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign evt  = evt_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel conditioner for asynchronous board inputs.
// Build option: INPUT_CONDITIONER_DEBOUNCE_EN enables per-channel debounce.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   u           : raw asynchronous inputs, one bit per channel
//   evt_clr     : synchronous per-channel clear of evt
//   s           : conditioned levels
//   rise, fall  : one-cycle edge pulses
//   evt         : sticky event flags, edges selected per channel by EDGE_MODE
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned               CHANNELS        = 9,
  parameter int unsigned               SYNC_STAGES     = 2,
  parameter int unsigned               DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0]       RESET_VALUE     = '0,
  parameter logic [2*CHANNELS-1:0]     EDGE_MODE       = {CHANNELS{EDGE_BOTH}}
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [CHANNELS-1:0] u,
  output logic [CHANNELS-1:0] s,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] evt,
  input  logic [CHANNELS-1:0] evt_clr
);

  // Independent channels; per-channel parameters are sliced from the vectors.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i]),
      .EDGE_MODE      (EDGE_MODE[2*i +: 2])
    ) u_ch (
      .clk    (clk),
      .nreset (nreset),
      .u      (u[i]),
      .evt_clr(evt_clr[i]),
      .s      (s[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .evt    (evt[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int unsigned N  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam bit          DEB = 1'b1;
  localparam int unsigned LAT = SS + DC;
`else
  localparam bit          DEB = 1'b0;
  localparam int unsigned LAT = SS + 1;
`endif

  logic         clk = 1'b0;
  logic         nreset;
  logic [N-1:0] u, s, rise, fall, evt, evt_clr;

  input_conditioner #(
    .CHANNELS       (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VALUE    (4'h0),
    .EDGE_MODE      (8'b11_10_01_11)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .u      (u),
    .s      (s),
    .rise   (rise),
    .fall   (fall),
    .evt    (evt),
    .evt_clr(evt_clr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int          ch;
    bit          is_rise;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int unsigned at, input int ch, input bit is_rise);
    exp_t e;
    e.at = at; e.ch = ch; e.is_rise = is_rise;
    q.push_back(e);
  endtask

  task automatic got_pulse(input int ch, input bit is_rise);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_pulse: ch %0d %s at cycle %0d, expected none",
               ch, is_rise ? "rise" : "fall", cyc);
    end else begin
      e = q.pop_front();
      check("pulse_id", ch * 2 + int'(is_rise), e.ch * 2 + int'(e.is_rise));
      check("pulse_cycle", int'(cyc), int'(e.at));
    end
  endtask

  // Monitor: every rise/fall pulse is matched against the expected queue.
  always @(negedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      if (rise[ch]) got_pulse(ch, 1'b1);
      if (fall[ch]) got_pulse(ch, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int unsigned c;

  initial begin
    nreset  = 1'b0;
    u       = '0;
    evt_clr = '0;
    tick(2);
    check("rst_s", int'(s), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_evt", int'(evt), 0);
    nreset = 1'b1;
    tick(20);
    check("idle_s", int'(s), 0);
    check("idle_evt", int'(evt), 0);

    // Channel 0 rise, evt set, evt clear.
    u[0] = 1'b1; c = cyc;
    expect_pulse(c + LAT, 0, 1'b1);
    tick(LAT - 1);
    check("s0_before", int'(s[0]), 0);
    tick(1);
    check("s0_after", int'(s[0]), 1);
    check("evt0_not_yet", int'(evt[0]), 0);
    tick(1);
    check("evt0_set", int'(evt[0]), 1);
    check("rise0_one_cycle", int'(rise[0]), 0);
    evt_clr[0] = 1'b1;
    tick(1);
    evt_clr[0] = 1'b0;
    check("evt0_cleared", int'(evt[0]), 0);

    // Channel 1 glitch (3 cycles high).
    u[1] = 1'b1; c = cyc;
    tick(3);
    u[1] = 1'b0;
    if (!DEB) begin
      expect_pulse(c + 3, 1, 1'b1);
      expect_pulse(c + 6, 1, 1'b0);
    end
    tick(10);
    check("glitch_s1", int'(s[1]), 0);
    check("glitch_evt1", int'(evt[1]), DEB ? 0 : 1);
    evt_clr[1] = 1'b1;
    tick(1);
    evt_clr[1] = 1'b0;
    // A full-length level after the glitch still needs the whole count.
    u[1] = 1'b1; c = cyc;
    expect_pulse(c + LAT, 1, 1'b1);
    tick(LAT - 1);
    check("s1_before", int'(s[1]), 0);
    tick(1);
    check("s1_after", int'(s[1]), 1);
    tick(1);
    check("evt1_rise_mode", int'(evt[1]), 1);

    // Channel 2 fall-only.
    u[2] = 1'b1; c = cyc;
    expect_pulse(c + LAT, 2, 1'b1);
    tick(10);
    check("s2_high", int'(s[2]), 1);
    check("evt2_no_rise_set", int'(evt[2]), 0);
    u[2] = 1'b0; c = cyc;
    expect_pulse(c + LAT, 2, 1'b0);
    tick(LAT);
    check("s2_low", int'(s[2]), 0);
    check("evt2_before", int'(evt[2]), 0);
    tick(1);
    check("evt2_fall_set", int'(evt[2]), 1);
    tick(8);

    // Set and clear on the same edge: set wins.
    u[0] = 1'b0; c = cyc;
    expect_pulse(c + LAT, 0, 1'b0);
    tick(LAT);
    evt_clr[0] = 1'b1;
    tick(1);
    evt_clr[0] = 1'b0;
    check("evt0_set_wins", int'(evt[0]), 1);
    evt_clr[0] = 1'b1;
    tick(1);
    check("evt0_clr", int'(evt[0]), 0);
    tick(1);
    evt_clr[0] = 1'b0;
    check("evt0_clr_idle", int'(evt[0]), 0);
    tick(4);

    // Reset mid-count (cnt[0] == 2 with debounce).
    u[0] = 1'b1; c = cyc;
    tick(DEB ? 4 : 1);
    check("pre_rst_s", int'(s), 4'b0010);
    nreset = 1'b0;
    #1;
    check("mid_rst_s", int'(s), 0);
    check("mid_rst_evt", int'(evt), 0);
    check("mid_rst_pulses", int'(rise | fall), 0);
    tick(3);
    nreset = 1'b1; c = cyc;
    expect_pulse(c + LAT, 0, 1'b1);
    expect_pulse(c + LAT, 1, 1'b1);
    tick(LAT + 2);
    check("post_rst_s", int'(s), 4'b0011);

    // Channel 3 rise latency.
    u[3] = 1'b1; c = cyc;
    expect_pulse(c + LAT, 3, 1'b1);
    tick(LAT - 1);
    check("s3_before", int'(s[3]), 0);
    tick(1);
    check("s3_after", int'(s[3]), 1);
    check("rise3_level", int'(rise[3]), 1);
    tick(2);
    check("evt3", int'(evt[3]), 1);

    // Drain: every expected pulse must have appeared.
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    check("pending_pulses", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised N-channel conditioner for asynchronous board inputs: interrupt lines, DIP switches, the DTR line and frame-done strobes. Each channel is synchronised into the `clk` domain, optionally debounced, and edge-detected, with per-channel sticky event flags for the CPU interrupt path. It is the generalised successor of the fixed 9-channel stabilizer that sits at the top level of FPGC5.

## Interface
Parameters:
- `CHANNELS`, 9, number of independent input channels (≥1)
- `SYNC_STAGES`, 2, synchroniser flop depth per channel (≥2)
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required before `s` changes (≥1; ignored when debounce is compiled out)
- `RESET_VALUE`, `{CHANNELS{1'b0}}`, reset level of the sync chain and of `s`, per channel
- `EDGE_MODE`, `{CHANNELS{2'b11}}`, 2 bits per channel selecting which edges set `evt`: 00 none, 01 rise, 10 fall, 11 both

Ports:
- `clk`  in  1  system clock (50 MHz)
- `nreset`  in  1  asynchronous, active-low reset
- `u`  in  CHANNELS  unsynchronised raw inputs
- `s`  out  CHANNELS  stable, conditioned levels
- `rise`  out  CHANNELS  one-cycle pulse when `s[i]` goes 0→1
- `fall`  out  CHANNELS  one-cycle pulse when `s[i]` goes 1→0
- `evt`  out  CHANNELS  sticky event flags, selected by `EDGE_MODE`
- `evt_clr`  in  CHANNELS  synchronous per-channel clear of `evt`

## Operation
- Channels are fully independent. No state is shared between channels.
- Sync chain: `u[i]` shifts through `SYNC_STAGES` flops. The last stage is `y[i]`.
- Debounce counter: width is clog2(`DEBOUNCE_CYCLES`)+1.
  - Each edge with `y[i]` != `s[i]` increments `cnt`.
  - Any edge with `y[i]` == `s[i]` zeroes `cnt`, so a glitch restarts the count.
  - When `y[i]` != `s[i]` and `cnt` == `DEBOUNCE_CYCLES`-1: load `s[i]` <= `y[i]` and set `cnt` to 0. The counter never exceeds `DEBOUNCE_CYCLES`-1.
- `rise` and `fall` are registered. They assert in the same cycle that the new `s[i]` value is first visible, for exactly one cycle.
- `evt[i]`: set on the edge after a selected `rise`/`fall` pulse. It holds until an `evt_clr[i]` is sampled.
  - If set and clear occur on the same edge, set wins.
  - A clear on an already-clear flag has no effect.
- Reset (asynchronous assert, synchronous-safe release):
  - Sync flops and `s` go to `RESET_VALUE`.
  - `cnt`, `rise`, `fall` and `evt` go to 0.
  - Reset mid-count discards the count.
  - After release, an input that differs from `RESET_VALUE` produces a normal, fully debounced edge. This behaviour is required.

## Timing
- Number the edges from the first edge that samples a new stable level of `u[i]` as edge 1.
- With debounce:
  - `y[i]` updates at edge `SYNC_STAGES`.
  - `s[i]`, `rise[i]` and `fall[i]` update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - `evt[i]` updates one edge later.
- A pulse on `u[i]` whose `y[i]` lasts fewer than `DEBOUNCE_CYCLES` cycles produces no change on any output.
- Without debounce: `s[i]` updates at edge `SYNC_STAGES`+1. Every `y[i]` transition propagates.
- `evt_clr` takes effect on the next edge. `evt` reads 0 in the following cycle unless a new set occurs on that same edge.
- `u` is the only asynchronous input. `evt_clr` must be synchronous to `clk`.

## Configuration
- `INPUT_CONDITIONER_DEBOUNCE_EN`: when defined, per-channel debounce counters are instantiated and `DEBOUNCE_CYCLES` applies.
- When undefined, no counters exist. `s` is a single register after the sync chain, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `input_conditioner_pkg` holds:
  - edge-mode constants `EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH` (2'b00, 2'b01, 2'b10, 2'b11)
  - a `clog2` function for the counter width
- Sub-module `cond_channel` implements one channel (sync, debounce, edge, evt). The top generates `CHANNELS` instances, and `EDGE_MODE` and `RESET_VALUE` are sliced per channel.

## Test plan
Bench: `CHANNELS`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `EDGE_MODE`=8'b11_10_01_11, macro defined unless noted.
- Reset with `u`=4'h0 → `s`/`rise`/`fall`/`evt` = 0. Release with `u`=4'h0 held for 20 cycles → no pulses.
- `u[0]` 0→1 held → `s[0]`=1 and a one-cycle `rise[0]` at edge 6. `evt[0]`=1 at edge 7. `evt_clr[0]` pulse → `evt[0]`=0 the next cycle.
- `u[1]` high for 3 cycles then low → `s[1]`, `rise[1]`, `fall[1]` and `evt[1]` stay 0. Check that the count restarts on the glitch.
- `u[2]` (fall-only) 0→1→0, each level held 10 cycles → `rise[2]` and `fall[2]` both pulse. `evt[2]` is set only after `fall[2]`.
- `evt_clr[0]` asserted on the same edge as a new `evt[0]` set → `evt[0]` remains 1.
- `nreset` asserted while `cnt[0]`=2 → all outputs 0 immediately. With macro undefined, `u[3]` 0→1 → `s[3]` and `rise[3]` at edge 3.
